matrix_scan_scheduler: RTL and testbench
========================================

# matrix_scan_scheduler

Scan scheduler for the 8x8 LED matrix. It accepts whole 64-bit frames from a producer (LFSR, pattern engine, MCU bridge) over a valid/ready handshake and holds them in a double buffer. It time-multiplexes the front frame onto the matrix one row at a time, with a blanking phase and a global brightness level. Frames swap only at frame boundaries, so the display never tears.

## Interface
- PRESCALE, default 1024: clock cycles per phase tick; legal range ≥ 2.
- i_CLK  in  1  system clock; all logic on its rising edge.
- i_RST  in  1  reset, synchronous, active-high.
- i_Frame_Data  in  64  frame pixels; bit r*8+c is row r, column c (bit 0 is row 0, column 0); 1 means lit.
- i_Frame_Valid  in  1  producer offers i_Frame_Data.
- o_Frame_Ready  out  1  back buffer free; equals !pending.
- i_Brightness  in  3  lit phases per row slot, 0..7.
- o_Frame_Sync  out  1  one-cycle pulse in the first cycle of each frame.
- rows  out  8  one-hot row select, active-high.
- columns  out  8  column data for the selected row, active-high.

## Operation
- **Prescaler**
  - Counts 0..PRESCALE-1 and wraps.
  - `tick` is asserted in the cycle where the count equals PRESCALE-1.
- **Scan counters**
  - `phase` is 3 bits, `row` is 3 bits.
  - `phase` advances on each tick.
  - When `phase` wraps 7→0, `row` advances, wrapping 7→0.
- **Row slot**: 8 phases.
  - Phase 0 is blanking: rows and columns are 0.
  - On entry to phase 0, `bright_lat` ← i_Brightness.
  - Phases 1..7: lit when phase ≤ bright_lat; dark otherwise.
  - While lit: rows = 1<<row and columns = front[row*8 +: 8].
  - While dark: rows = 0 and columns = 0.
- **Handshake**
  - A frame is accepted when i_Frame_Valid && o_Frame_Ready at a rising edge.
  - On accept: back ← i_Frame_Data and pending ← 1.
  - Offers made while ready is low are ignored; the producer must hold valid.
- **Frame boundary**: the tick edge where row=7, phase=7 moves to row=0, phase=0. On that edge:
  - If pending: front ← back and pending ← 0.
  - o_Frame_Sync is 1 for the following cycle only.
- **Accept and boundary on the same edge**: impossible, because ready is low while pending and the swap happens only while pending. Ready rises in the cycle after the swap.
- **Reset** (also when asserted mid-frame), on the next edge:
  - prescaler, phase, row, bright_lat ← 0.
  - front, back ← 0.
  - pending ← 0, so o_Frame_Ready = 1.
  - rows, columns, o_Frame_Sync ← 0.
  - No sync pulse at reset exit. The first pulse comes at the first boundary, 64*PRESCALE cycles after reset release.

## Timing
- rows, columns and o_Frame_Sync are registers. They are updated on the same edge that updates phase/row, so they reflect the new phase with no extra cycle of latency.
- Row slot lasts 8*PRESCALE cycles; frame lasts 64*PRESCALE cycles (PRESCALE=1024 at 12 MHz gives 65536 cycles, about 183 Hz).
- Lit time per row is bright_lat*PRESCALE cycles. Blanking lasts at least PRESCALE cycles between rows.
- Accept-to-display latency: from 1 cycle up to 64*PRESCALE cycles (display changes at the next boundary).
- A brightness change takes effect at the next row's phase 0; it never applies mid-row.
- o_Frame_Ready is combinational from the pending register.

## Structure
- Shared package `matrix_pkg`: ROWS=8, COLS=8, FRAME_BITS=64, PHASES=8, BRIGHT_W=3.
- One sub-module, `tick_gen`: parameterised prescaler that outputs the single-cycle `tick`.
- Everything else lives in the top: scan counters, double buffer, handshake, and output registers.
- Prescaler width is $clog2(PRESCALE).

## Test plan
All scenarios use PRESCALE=4 (phase 4 cycles, row 32 cycles, frame 256 cycles).
- **Reset**: assert i_RST for 3 cycles mid-scan → next cycle rows=0, columns=0, o_Frame_Sync=0, o_Frame_Ready=1. The first sync pulse comes 256 cycles after release.
- **Diagonal frame**: load 64'h8040201008040201 with brightness 7 → after the boundary, each row r shows rows=1<<r, columns=1<<r for 28 cycles, preceded by 4 blank cycles.
- **Brightness levels**: brightness 0 → rows=0 for an entire frame. Brightness 3 → each row lit exactly 12 of 32 cycles, in phases 1..3.
- **Back-to-back offers**: offer A, then B held valid → A accepted and ready drops. B is accepted exactly 1 cycle after the swap. A is displayed for one full frame, then B.
- **Mid-row brightness change**: switch 7→2 during row 3 phase 4 → row 3 stays lit through phase 7; row 4 is lit in phases 1..2 only.
- **Mid-frame reset**: reset with a pending frame → pending is dropped and front is cleared. After release the display stays dark until a new frame is accepted and swapped in.

Source files
------------

// File: rtl/matrix_scan_scheduler_pkg.sv
// Shared constants and helpers for the 8x8 LED matrix scan scheduler.
package matrix_pkg;

    localparam int ROWS       = 8;
    localparam int COLS       = 8;
    localparam int FRAME_BITS = 64;
    localparam int PHASES     = 8;
    localparam int BRIGHT_W   = 3;

    localparam int ROW_W   = $clog2(ROWS);
    localparam int PHASE_W = $clog2(PHASES);

    // Position of the scan inside a frame: which row, which phase of its slot.
    typedef struct packed {
        logic [ROW_W-1:0]   row;
        logic [PHASE_W-1:0] phase;
    } scan_pos_t;

    // Phase 0 is always blanking; phases 1..bright are lit, the rest dark.
    function automatic logic lit_phase(input logic [PHASE_W-1:0] phase,
                                       input logic [BRIGHT_W-1:0] bright);
        return (phase != '0) && ({{(BRIGHT_W-PHASE_W){1'b0}}, phase} <= bright);
    endfunction

endpackage

// File: rtl/matrix_scan_scheduler_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 and flags the last count as a one-cycle tick.
module tick_gen #(
    parameter int PRESCALE = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int                CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap to zero after the last count.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/matrix_scan_scheduler.sv
// Double-buffered 8x8 LED matrix scan scheduler with blanking and brightness.
module matrix_scan_scheduler
    import matrix_pkg::*;
#(
    parameter int PRESCALE = 1024
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [FRAME_BITS-1:0] i_Frame_Data,
    input  logic                  i_Frame_Valid,
    output logic                  o_Frame_Ready,
    input  logic [BRIGHT_W-1:0]   i_Brightness,
    output logic                  o_Frame_Sync,
    output logic [ROWS-1:0]       rows,
    output logic [COLS-1:0]       columns
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASES - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [ROWS-1:0]    ROW_ONE    = ROWS'(1);

    logic tick;

    scan_pos_t             pos_q, pos_d;
    logic [BRIGHT_W-1:0]   bright_q, bright_d;
    logic [FRAME_BITS-1:0] front_q, front_d;
    logic [FRAME_BITS-1:0] back_q, back_d;
    logic                  pending_q, pending_d;
    logic [ROWS-1:0]       rows_q, rows_d;
    logic [COLS-1:0]       cols_q, cols_d;
    logic                  sync_q, sync_d;
    logic                  boundary;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk_i (i_CLK),
        .rst_i (i_RST),
        .tick_o(tick)
    );

    // Next-state logic: handshake, frame swap, scan advance and output decode.
    always_comb begin
        pos_d     = pos_q;
        bright_d  = bright_q;
        front_d   = front_q;
        back_d    = back_q;
        pending_d = pending_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        sync_d    = 1'b0;

        boundary = tick && (pos_q.row == ROW_LAST) && (pos_q.phase == PHASE_LAST);

        // Accept and swap never coincide: accept needs !pending, swap needs pending.
        if (i_Frame_Valid && !pending_q) begin
            back_d    = i_Frame_Data;
            pending_d = 1'b1;
        end
        if (boundary && pending_q) begin
            front_d   = back_q;
            pending_d = 1'b0;
        end

        // Outputs are decoded from the new position so they change with it.
        if (tick) begin
            pos_d.phase = pos_q.phase + 1'b1;
            if (pos_q.phase == PHASE_LAST) begin
                pos_d.row = pos_q.row + 1'b1;
            end
            if (pos_d.phase == '0) begin
                bright_d = i_Brightness;
            end
            rows_d = '0;
            cols_d = '0;
            if (lit_phase(pos_d.phase, bright_d)) begin
                rows_d = ROW_ONE << pos_d.row;
                cols_d = front_d[{pos_d.row, 3'b000} +: COLS];
            end
            sync_d = boundary;
        end
    end

    // State and output registers, all cleared by reset.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            pos_q     <= '0;
            bright_q  <= '0;
            front_q   <= '0;
            back_q    <= '0;
            pending_q <= 1'b0;
            rows_q    <= '0;
            cols_q    <= '0;
            sync_q    <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            bright_q  <= bright_d;
            front_q   <= front_d;
            back_q    <= back_d;
            pending_q <= pending_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            sync_q    <= sync_d;
        end
    end

    assign o_Frame_Ready = !pending_q;
    assign o_Frame_Sync  = sync_q;
    assign rows          = rows_q;
    assign columns       = cols_q;

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Scoreboard bench for matrix_scan_scheduler with PRESCALE=4
// (phase 4 cycles, row slot 32 cycles, frame 256 cycles).
module tb_matrix_scan_scheduler;

    typedef struct {
        int         cyc;
        int         kind;   // 0: rows/columns, 1: ready
        logic [7:0] rows;
        logic [7:0] cols;
        logic       rdy;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [2:0]  brightness;
    logic        frame_sync;
    logic [7:0]  rows_o;
    logic [7:0]  cols_o;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;
    exp_t chk_q[$];
    int   sync_q[$];
    exp_t e;
    int   exp_sync;

    localparam logic [63:0] DIAG  = 64'h8040201008040201;
    localparam logic [63:0] FRM_A = 64'hFF00FF00FF00FF00;
    localparam logic [63:0] FRM_B = 64'h0123456789ABCDEF;

    matrix_scan_scheduler #(.PRESCALE(4)) dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_Frame_Data (frame_data),
        .i_Frame_Valid(frame_valid),
        .o_Frame_Ready(frame_ready),
        .i_Brightness (brightness),
        .o_Frame_Sync (frame_sync),
        .rows         (rows_o),
        .columns      (cols_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input exp_t x);
        int i = 0;
        while (i < chk_q.size() && chk_q[i].cyc <= x.cyc) i++;
        chk_q.insert(i, x);
    endtask

    task automatic exp_out(input int c, input logic [7:0] r, input logic [7:0] co, input string n);
        exp_t x;
        x.cyc = c; x.kind = 0; x.rows = r; x.cols = co; x.rdy = 1'b0; x.name = n;
        push(x);
    endtask

    task automatic exp_rdy(input int c, input logic v, input string n);
        exp_t x;
        x.cyc = c; x.kind = 1; x.rows = '0; x.cols = '0; x.rdy = v; x.name = n;
        push(x);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: pops due expectations and sync pulses, compares, reports.
    always @(negedge clk) begin
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            e = chk_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s missed_at=%0d now=%0d", e.name, e.cyc, cyc);
            end else if (e.kind == 0) begin
                if (rows_o !== e.rows || cols_o !== e.cols) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got rows=%h cols=%h want rows=%h cols=%h",
                             e.name, cyc, rows_o, cols_o, e.rows, e.cols);
                end
            end else begin
                if (frame_ready !== e.rdy) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got ready=%b want ready=%b",
                             e.name, cyc, frame_ready, e.rdy);
                end
            end
        end
        if (frame_sync === 1'b1) begin
            checks++;
            if (sync_q.size() == 0) begin
                failures++;
                $display("FAIL sync_unexpected cyc=%0d got pulse want none", cyc);
            end else begin
                exp_sync = sync_q.pop_front();
                if (exp_sync != cyc) begin
                    failures++;
                    $display("FAIL sync_time got cyc=%0d want cyc=%0d", cyc, exp_sync);
                end
            end
        end
        if (done) begin
            while (chk_q.size() > 0) begin
                e = chk_q.pop_front();
                checks++;
                failures++;
                $display("FAIL %s never_checked cyc=%0d", e.name, e.cyc);
            end
            while (sync_q.size() > 0) begin
                exp_sync = sync_q.pop_front();
                checks++;
                failures++;
                $display("FAIL sync_missing got none want cyc=%0d", exp_sync);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no finish want finish by t=100000");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: reset, frames and brightness changes at fixed cycles.
    initial begin
        int R;
        rst = 1'b1; frame_valid = 1'b0; frame_data = '0; brightness = 3'd7;

        // Power-up reset (edges 1..3), then a frame that stays pending.
        exp_rdy(4, 1'b0, "ready_low_after_accept");
        exp_rdy(103, 1'b0, "ready_low_while_pending");
        exp_out(103, 8'h08, 8'h00, "premid_row3_lit_empty");
        exp_out(104, 8'h00, 8'h00, "reset_outputs_zero");
        exp_rdy(104, 1'b1, "reset_ready_high");
        wait_until(3);
        rst = 1'b0;
        frame_valid = 1'b1; frame_data = DIAG;
        wait_until(4);
        frame_valid = 1'b0;

        // Mid-frame reset for 3 cycles with a pending frame.
        wait_until(103);
        rst = 1'b1;
        wait_until(106);
        rst = 1'b0;
        R = 106;

        for (int k = 1; k <= 9; k++) sync_q.push_back(R + 256 * k);

        exp_out(R + 8,   8'h00, 8'h00, "row0_dark_bright_reset");
        exp_out(R + 36,  8'h02, 8'h00, "after_reset_front_clear");
        exp_rdy(R + 261, 1'b0, "diag_accepted");
        exp_out(R + 300, 8'h02, 8'h00, "pending_dropped_by_reset");
        exp_rdy(R + 512, 1'b1, "ready_after_swap");
        for (int r = 0; r < 8; r++) begin
            exp_out(R + 512 + 32 * r + 1,  8'h00, 8'h00, "diag_blank");
            exp_out(R + 512 + 32 * r + 4,  8'(1 << r), 8'(1 << r), "diag_lit_p1");
            exp_out(R + 512 + 32 * r + 31, 8'(1 << r), 8'(1 << r), "diag_lit_p7");
        end
        for (int k = 0; k < 32; k++) begin
            if (k >= 4 && k < 16) exp_out(R + 832 + k, 8'h04, 8'h04, "bright3_row2");
            else                  exp_out(R + 832 + k, 8'h00, 8'h00, "bright3_row2");
        end
        exp_out(R + 1000, 8'h80, 8'h80, "bright3_row7_p2");
        exp_out(R + 1008, 8'h00, 8'h00, "bright3_row7_p4");
        for (int k = 0; k < 64; k++) exp_out(R + 1024 + 4 * k + 2, 8'h00, 8'h00, "bright0_dark");
        exp_out(R + 1393, 8'h08, 8'h08, "midrow_row3_p4");
        exp_out(R + 1397, 8'h08, 8'h08, "midrow_row3_p5");
        exp_out(R + 1401, 8'h08, 8'h08, "midrow_row3_p6");
        exp_out(R + 1405, 8'h08, 8'h08, "midrow_row3_p7");
        exp_out(R + 1407, 8'h08, 8'h08, "midrow_row3_p7_end");
        exp_out(R + 1409, 8'h00, 8'h00, "midrow_row4_blank");
        exp_out(R + 1412, 8'h10, 8'h10, "midrow_row4_p1");
        exp_out(R + 1419, 8'h10, 8'h10, "midrow_row4_p2");
        exp_out(R + 1420, 8'h00, 8'h00, "midrow_row4_p3");
        exp_out(R + 1430, 8'h00, 8'h00, "midrow_row4_p5");
        exp_out(R + 1439, 8'h00, 8'h00, "midrow_row4_p7");
        exp_rdy(R + 1541, 1'b0, "b2b_a_accepted");
        exp_rdy(R + 1791, 1'b0, "b2b_b_blocked");
        exp_rdy(R + 1792, 1'b1, "b2b_ready_after_swap");
        exp_rdy(R + 1793, 1'b0, "b2b_b_accepted");
        exp_rdy(R + 1794, 1'b0, "b2b_b_pending");
        exp_out(R + 1802, 8'h01, 8'h00, "frame_a_row0");
        exp_out(R + 1841, 8'h02, 8'hFF, "frame_a_row1");
        exp_out(R + 1918, 8'h08, 8'hFF, "frame_a_row3");
        exp_out(R + 2058, 8'h01, 8'hEF, "frame_b_row0");
        exp_out(R + 2164, 8'h08, 8'h89, "frame_b_row3");
        exp_out(R + 2300, 8'h80, 8'h01, "frame_b_row7");

        wait_until(R + 260);
        frame_valid = 1'b1; frame_data = DIAG;
        wait_until(R + 261);
        frame_valid = 1'b0;

        wait_until(R + 745);
        brightness = 3'd3;
        wait_until(R + 1000);
        brightness = 3'd0;
        wait_until(R + 1270);
        brightness = 3'd7;
        wait_until(R + 1393);
        brightness = 3'd2;
        wait_until(R + 1440);
        brightness = 3'd7;

        wait_until(R + 1540);
        frame_valid = 1'b1; frame_data = FRM_A;
        wait_until(R + 1541);
        frame_data = FRM_B;
        wait_until(R + 1793);
        frame_valid = 1'b0;

        wait_until(R + 2310);
        done = 1'b1;
    end

endmodule
